sram_arbiter: RTL and testbench

- Shares the single SDRAM byte port between three requesters:
  - the data_io download path (ioctl writes),
  - the CPU memory cycles,
  - the tape player's refresh-window reads.
- Replaces the ad-hoc priority muxing on the sram instance with a slot-based scheduler.
- Provides per-requester handshakes, a one-entry download write buffer and a tape read cache.
- Sits between the CPU/data_io/tape blocks and the sram controller, all in the clk_sys domain.

---
 rtl/sram_arbiter_if.sv | 48 ++++
 rtl/sram_arbiter.sv | 143 ++++++++++++++
 tb/tb_sram_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the requesters (CPU, data_io download, tape player),
// the SDRAM byte port and the slot arbiter.
interface sram_arbiter_if #(
  parameter int AW = 25
);
  logic          dl_busrq;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          dl_overflow;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;
  logic          rfsh;

  logic          tape_req;
  logic [AW-1:0] tape_addr;
  logic [7:0]    tape_data;
  logic          tape_valid;

  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic          mem_rd;
  logic [7:0]    mem_dout;

  // arbiter side
  modport slave (
    input  dl_busrq, dl_wr, dl_addr, dl_data,
    input  cpu_req, cpu_we, cpu_addr, cpu_din, rfsh,
    input  tape_req, tape_addr, mem_dout,
    output dl_overflow, cpu_dout, cpu_ack, tape_data, tape_valid,
    output mem_addr, mem_din, mem_we, mem_rd
  );

  // requester / memory side
  modport master (
    output dl_busrq, dl_wr, dl_addr, dl_data,
    output cpu_req, cpu_we, cpu_addr, cpu_din, rfsh,
    output tape_req, tape_addr, mem_dout,
    input  dl_overflow, cpu_dout, cpu_ack, tape_data, tape_valid,
    input  mem_addr, mem_din, mem_we, mem_rd
  );
endinterface

// File: rtl/sram_arbiter.sv
// Slot-based scheduler sharing the SDRAM byte port between the download
// path, CPU memory cycles and tape refresh-window reads. Each access owns
// a fixed slot of SLOT cycles; one idle cycle separates slots.
module sram_arbiter #(
  parameter int AW     = 25,
  parameter int SLOT   = 8,
  parameter int RD_LAT = 6
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  bus
);
  localparam int CW = $clog2(SLOT);

  typedef enum logic       {ST_IDLE, ST_SLOT} state_t;
  typedef enum logic [1:0] {G_DL, G_CPU, G_TAPE} gnt_t;

  state_t        state;
  gnt_t          gnt;
  logic [CW-1:0] cnt;

  logic          dl_full;
  logic [AW-1:0] dl_addr_q;
  logic [7:0]    dl_data_q;
  logic          cpu_served;
  logic          tape_pend;
  logic [AW-1:0] tape_addr_q;
  logic          cache_valid;
  logic [AW-1:0] cache_addr;

  logic last, dl_done, cpu_elig, tape_elig, cache_hit;

  // slot bookkeeping and eligibility (priority resolved in the FSM)
  assign last      = (state == ST_SLOT) && (cnt == CW'(SLOT-1));
  assign dl_done   = last && (gnt == G_DL);
  assign cpu_elig  = bus.cpu_req && !bus.dl_busrq && !cpu_served;
  assign tape_elig = tape_pend && bus.rfsh && !bus.cpu_req;
  // tape_data doubles as the cache data register: it only changes on tape reads
  assign cache_hit = cache_valid && (bus.tape_addr == cache_addr);

  // scheduler FSM, request capture and registered memory/handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      gnt             <= G_DL;
      cnt             <= '0;
      dl_full         <= 1'b0;
      dl_addr_q       <= '0;
      dl_data_q       <= '0;
      cpu_served      <= 1'b0;
      tape_pend       <= 1'b0;
      tape_addr_q     <= '0;
      cache_valid     <= 1'b0;
      cache_addr      <= '0;
      bus.dl_overflow <= 1'b0;
      bus.cpu_dout    <= '0;
      bus.cpu_ack     <= 1'b0;
      bus.tape_data   <= '0;
      bus.tape_valid  <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_din     <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_rd      <= 1'b0;
    end else begin
      bus.cpu_ack    <= 1'b0;
      bus.tape_valid <= 1'b0;
      if (!bus.cpu_req) cpu_served <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (dl_full || cpu_elig || tape_elig) begin
            state <= ST_SLOT;
            cnt   <= '0;
          end
          if (dl_full) begin
            gnt          <= G_DL;
            bus.mem_addr <= dl_addr_q;
            bus.mem_din  <= dl_data_q;
            bus.mem_we   <= 1'b1;
          end else if (cpu_elig) begin
            gnt          <= G_CPU;
            cpu_served   <= 1'b1;
            bus.mem_addr <= bus.cpu_addr;
            bus.mem_din  <= bus.cpu_din;
            bus.mem_we   <= bus.cpu_we;
            bus.mem_rd   <= !bus.cpu_we;
          end else if (tape_elig) begin
            gnt          <= G_TAPE;
            tape_pend    <= 1'b0;
            bus.mem_addr <= tape_addr_q;
            bus.mem_rd   <= 1'b1;
          end
        end
        ST_SLOT: begin
          cnt <= cnt + 1'b1;
          // strobe low in the last cycle so back-to-back slots show an edge
          if (cnt == CW'(SLOT-2)) begin
            bus.mem_we <= 1'b0;
            bus.mem_rd <= 1'b0;
            if (gnt == G_CPU)  bus.cpu_ack    <= 1'b1;
            if (gnt == G_TAPE) bus.tape_valid <= 1'b1;
          end
          if (cnt == CW'(RD_LAT) && bus.mem_rd) begin
            if (gnt == G_CPU)  bus.cpu_dout  <= bus.mem_dout;
            if (gnt == G_TAPE) bus.tape_data <= bus.mem_dout;
          end
          if (last) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (gnt == G_DL) begin
              dl_full     <= 1'b0;
              cache_valid <= 1'b0;
            end
            if (gnt == G_TAPE) begin
              cache_addr  <= bus.mem_addr;
              cache_valid <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // new requests override the grant/completion updates above
      if (bus.tape_req) begin
        if (cache_hit) begin
          bus.tape_valid <= 1'b1;
        end else begin
          tape_pend   <= 1'b1;
          tape_addr_q <= bus.tape_addr;
        end
      end
      if (bus.dl_wr) begin
        if (!dl_full || dl_done) begin
          dl_full   <= 1'b1;
          dl_addr_q <= bus.dl_addr;
          dl_data_q <= bus.dl_data;
        end else begin
          bus.dl_overflow <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: memory model returns addr[7:0]^0x5A, a negedge
// monitor pops expected memory/handshake events from a scoreboard queue.
module tb_sram_arbiter;
  localparam int AW = 25, SLOT = 8, RD_LAT = 6;
  localparam int K_W = 0, K_R = 1, K_ACK = 2, K_TV = 3;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.AW(AW)) bus ();
  sram_arbiter #(.AW(AW), .SLOT(SLOT), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  assign bus.mem_dout = bus.mem_addr[7:0] ^ 8'h5A;

  typedef struct {int kind; logic [AW-1:0] addr; logic [7:0] data; bit ca; bit cd;} ev_t;
  typedef struct {logic we; logic [AW-1:0] addr; logic [7:0] din; logic [7:0] dout;} vec_t;
  ev_t  sb[$];
  vec_t tbl[5];
  int total = 0, bad = 0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endfunction

  function automatic void push(int k, logic [AW-1:0] a, logic [7:0] d, bit ca, bit cd);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.ca = ca; e.cd = cd;
    sb.push_back(e);
  endfunction

  function automatic void pop(int k, logic [AW-1:0] a, logic [7:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_event kind=%0d addr=%h data=%h t=%0t", k, a, d, $time);
      return;
    end
    e = sb.pop_front();
    chk("ev_kind", 32'(k), 32'(e.kind));
    if (e.ca) chk("ev_addr", 32'(a), 32'(e.addr));
    if (e.cd) chk("ev_data", 32'(d), 32'(e.data));
  endfunction

  // monitor: strobe rises, strobe length, ack/valid pulses
  logic prev_we = 1'b0, prev_rd = 1'b0;
  int   run = 0;
  always @(negedge clk) begin
    if (bus.mem_we && !prev_we) pop(K_W, bus.mem_addr, bus.mem_din);
    if (bus.mem_rd && !prev_rd) pop(K_R, bus.mem_addr, 8'h00);
    if (bus.cpu_ack) begin
      chk("ack_at_last_cycle", 32'(prev_we | prev_rd), 32'd1);
      pop(K_ACK, '0, bus.cpu_dout);
    end
    if (bus.tape_valid) pop(K_TV, '0, bus.tape_data);
    if (reset) begin
      run = 0;
    end else if (bus.mem_we || bus.mem_rd) begin
      run++;
    end else if (prev_we || prev_rd) begin
      chk("strobe_len", 32'(run), 32'(SLOT-1));
      run = 0;
    end
    prev_we = reset ? 1'b0 : bus.mem_we;
    prev_rd = reset ? 1'b0 : bus.mem_rd;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || bus.mem_we || bus.mem_rd) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk({nm, "_timeout"}, 32'(sb.size()), 32'd0);
    tick(1);
  endtask

  task automatic dl_write(input logic [AW-1:0] a, input logic [7:0] d, input bit exp);
    bus.dl_wr = 1'b1; bus.dl_addr = a; bus.dl_data = d;
    if (exp) push(K_W, a, d, 1, 1);
    tick(1);
    bus.dl_wr = 1'b0;
  endtask

  task automatic tape_read(input logic [AW-1:0] a);
    bus.tape_req = 1'b1; bus.tape_addr = a;
    tick(1);
    bus.tape_req = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 25'h000C000, 8'h00, 8'h5A};
    tbl[1] = '{1'b1, 25'h0000123, 8'hC3, 8'h00};
    tbl[2] = '{1'b0, 25'h1FFFFFF, 8'h00, 8'hA5};
    tbl[3] = '{1'b1, 25'h0000000, 8'hFF, 8'h00};
    tbl[4] = '{1'b0, 25'h000003C, 8'h00, 8'h66};

    bus.dl_busrq = 0; bus.dl_wr = 0; bus.dl_addr = '0; bus.dl_data = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.rfsh = 0; bus.tape_req = 0; bus.tape_addr = '0;
    tick(3);
    @(negedge clk);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_cpu_ack", 32'(bus.cpu_ack), 0);
    chk("rst_tape_valid", 32'(bus.tape_valid), 0);
    chk("rst_overflow", 32'(bus.dl_overflow), 0);
    tick(1);
    reset = 1'b0;
    tick(2);

    // CPU accesses from the vector table; holding cpu_req must not re-grant
    for (int i = 0; i < 5; i++) begin
      bus.cpu_req = 1'b1; bus.cpu_we = tbl[i].we;
      bus.cpu_addr = tbl[i].addr; bus.cpu_din = tbl[i].din;
      if (tbl[i].we) push(K_W, tbl[i].addr, tbl[i].din, 1, 1);
      else           push(K_R, tbl[i].addr, 8'h00, 1, 0);
      push(K_ACK, '0, tbl[i].dout, 0, !tbl[i].we);
      wait_idle("cpu");
      tick(12);
      if (!tbl[i].we) chk("cpu_dout", 32'(bus.cpu_dout), 32'(tbl[i].dout));
      bus.cpu_req = 1'b0;
      tick(2);
    end

    // download burst, one write every 10 cycles
    bus.dl_busrq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dl_write(AW'(i), 8'h10 + 8'(i), 1);
      tick(9);
    end
    wait_idle("dl_burst");
    chk("no_overflow", 32'(bus.dl_overflow), 0);

    // writes every 2 cycles: only the first fits, the rest are dropped
    for (int i = 0; i < 4; i++) begin
      dl_write(AW'(8 + i), 8'h20 + 8'(i), i == 0);
      tick(1);
    end
    wait_idle("dl_ovf");
    chk("overflow_set", 32'(bus.dl_overflow), 1);
    bus.dl_busrq = 1'b0;
    tick(2);

    // priority: download, then CPU, tape only once cpu_req drops
    bus.rfsh = 1'b1;
    bus.dl_wr = 1'b1; bus.dl_addr = 25'h50; bus.dl_data = 8'h77;
    bus.tape_req = 1'b1; bus.tape_addr = 25'h2A5;
    push(K_W, 25'h50, 8'h77, 1, 1);
    tick(1);
    bus.dl_wr = 1'b0; bus.tape_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 25'h312;
    push(K_R, 25'h312, 8'h00, 1, 0);
    push(K_ACK, '0, 8'h48, 0, 1);
    wait_idle("prio_cpu");
    tick(20);
    push(K_R, 25'h2A5, 8'h00, 1, 0);
    push(K_TV, '0, 8'hFF, 0, 1);
    bus.cpu_req = 1'b0;
    wait_idle("prio_tape");

    // tape cache: miss, hit, invalidate by download, miss again
    push(K_R, 25'h100, 8'h00, 1, 0);
    push(K_TV, '0, 8'h5A, 0, 1);
    tape_read(25'h100);
    wait_idle("tape_miss");
    tick(3);
    push(K_TV, '0, 8'h5A, 0, 1);
    tape_read(25'h100);
    @(negedge clk);
    chk("hit_latency", 32'(bus.tape_valid), 1);
    chk("hit_no_rd", 32'(bus.mem_rd), 0);
    tick(5);
    dl_write(25'h400, 8'h33, 1);
    wait_idle("inv_dl");
    tick(2);
    push(K_R, 25'h100, 8'h00, 1, 0);
    push(K_TV, '0, 8'h5A, 0, 1);
    tape_read(25'h100);
    wait_idle("tape_refill");
    bus.rfsh = 1'b0;

    // reset during slot cycle 3 of a CPU write
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 25'h0C000; bus.cpu_din = 8'hAB;
    push(K_W, 25'h0C000, 8'hAB, 1, 1);
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.mem_we && n < 20) begin @(negedge clk); n++; end
      chk("rst_slot_started", 32'(bus.mem_we), 1);
    end
    tick(3);
    reset = 1'b1; bus.cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_mem_we", 32'(bus.mem_we), 0);
    chk("abort_cpu_ack", 32'(bus.cpu_ack), 0);
    chk("abort_mem_addr", 32'(bus.mem_addr), 0);
    chk("abort_mem_din", 32'(bus.mem_din), 0);
    chk("abort_overflow", 32'(bus.dl_overflow), 0);
    chk("abort_cpu_dout", 32'(bus.cpu_dout), 0);
    chk("abort_tape_data", 32'(bus.tape_data), 0);
    tick(1);
    reset = 1'b0;
    tick(20);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
